// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage: PC, imem address, IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state, state_d;
  logic [31:0] pc_d, ifid_pc_d, ifid_pc4_d, ifid_instr_d, fetch_count_d;
  logic        ifid_valid_d, misalign_err_d;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // State and pipeline-register update; reset discards any same-cycle redirect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      ifid_pc      <= 32'd0;
      ifid_pc4     <= 32'd0;
      ifid_instr   <= NOP_WORD;
      ifid_valid   <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      ifid_pc      <= ifid_pc_d;
      ifid_pc4     <= ifid_pc4_d;
      ifid_instr   <= ifid_instr_d;
      ifid_valid   <= ifid_valid_d;
      misalign_err <= misalign_err_d;
      fetch_count  <= fetch_count_d;
    end
  end

  // Next-state: BOOT is a memory-settle bubble; RUN applies redirect > stall > flush > fetch
  always_comb begin
    state_d        = state;
    pc_d           = pc;
    ifid_pc_d      = ifid_pc;
    ifid_pc4_d     = ifid_pc4;
    ifid_instr_d   = ifid_instr;
    ifid_valid_d   = ifid_valid;
    misalign_err_d = misalign_err;
    fetch_count_d  = fetch_count;
    case (state)
      BOOT: begin
        state_d      = RUN;
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end
      default: begin
        if (redirect_valid) begin
          pc_d         = {redirect_pc[31:2], 2'b00};
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) misalign_err_d = 1'b1;
        end else if (stall) begin
          // everything holds; a concurrent flush is re-asserted by the hazard unit later
        end else if (flush) begin
          pc_d         = pc_plus4;
          ifid_instr_d = NOP_WORD;
          ifid_valid_d = 1'b0;
        end else begin
          pc_d          = pc_plus4;
          ifid_instr_d  = imem_rdata;
          ifid_pc_d     = pc;
          ifid_pc4_d    = pc_plus4;
          ifid_valid_d  = 1'b1;
          fetch_count_d = fetch_count + 32'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int          WORDS    = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc, ifid_pc, ifid_pc4, ifid_instr, fetch_count;
  logic        ifid_valid, misalign_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [WORDS];

  // reference state: what the fetch stage should hold after each edge
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_count;
  logic        m_valid, m_err, m_boot;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc(pc), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // text window lookup; anything outside reads as a NOP word
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] off;
    off = a - RESET_PC;
    if (a >= RESET_PC && off < WORDS * 4) return mem[off[9:2]];
    return 32'd0;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_pc", ifid_pc, m_ifpc);
    chk("ifid_pc4", ifid_pc4, m_ifpc4);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    chk("fetch_count", fetch_count, m_count);
  endtask

  // apply one cycle of inputs, advance the reference by the stage's rules, compare
  task automatic tick(input logic r, input logic st, input logic fl,
                      input logic rv, input logic [31:0] rp);
    rst_n = r; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rp;
    if (!r) begin
      m_pc = RESET_PC; m_ifpc = 0; m_ifpc4 = 0; m_instr = NOP_WORD;
      m_valid = 0; m_err = 0; m_count = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0; m_valid = 0; m_instr = NOP_WORD;
    end else if (rv) begin
      m_pc = rp & 32'hFFFF_FFFC; m_valid = 0; m_instr = NOP_WORD;
      if (rp % 4 != 0) m_err = 1;
    end else if (st) begin
    end else if (fl) begin
      m_pc = m_pc + 4; m_valid = 0; m_instr = NOP_WORD;
    end else begin
      m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_instr = word_at(m_pc);
      m_valid = 1; m_count = m_count + 1; m_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h2008FFFF;
    mem[2] = 32'h21080001;
    rst_n = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    m_boot = 1; m_pc = RESET_PC; m_ifpc = 0; m_ifpc4 = 0; m_instr = NOP_WORD;
    m_valid = 0; m_err = 0; m_count = 0;
    #2;

    // T1 reset and boot bubble
    do_reset();
    chk("t1_rst_pc", pc, 32'h0040_0000);
    tick(1, 0, 0, 0, 0);
    chk("t1_boot_pc", pc, 32'h0040_0000);
    chk("t1_boot_valid", {31'd0, ifid_valid}, 32'd0);
    tick(1, 0, 0, 0, 0);
    chk("t1_first_pc", ifid_pc, 32'h0040_0000);
    chk("t1_first_instr", ifid_instr, 32'h2008FFFF);
    chk("t1_first_cnt", fetch_count, 32'd1);

    // T2 straight line
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
    chk("t2_ifid_pc", ifid_pc, 32'h0040_0010);
    chk("t2_pc4", ifid_pc4, 32'h0040_0014);
    chk("t2_cnt", fetch_count, 32'd5);

    // T3 stall at pc 0x00400008
    do_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0);
    chk("t3_pc", pc, 32'h0040_0008);
    chk("t3_ifid_pc", ifid_pc, 32'h0040_0004);
    chk("t3_cnt", fetch_count, 32'd2);
    tick(1, 0, 0, 0, 0);
    chk("t3_resume_pc", ifid_pc, 32'h0040_0008);
    chk("t3_resume_cnt", fetch_count, 32'd3);

    // T4 redirect overrides stall and flush
    tick(1, 1, 1, 1, 32'h0040_0008);
    chk("t4_pc", pc, 32'h0040_0008);
    chk("t4_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t4_err", {31'd0, misalign_err}, 32'd0);
    tick(1, 0, 0, 0, 0);
    chk("t4_instr", ifid_instr, 32'h21080001);

    // T5 misaligned redirect, sticky error
    tick(1, 0, 0, 1, 32'h0040_0006);
    chk("t5_pc", pc, 32'h0040_0004);
    chk("t5_err", {31'd0, misalign_err}, 32'd1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("t5_err_sticky", {31'd0, misalign_err}, 32'd1);

    // T6 flush at pc 0x0040000C, then reset during a redirect
    chk("t6_pre_pc", pc, 32'h0040_000C);
    tick(1, 0, 1, 0, 0);
    chk("t6_flush_valid", {31'd0, ifid_valid}, 32'd0);
    chk("t6_flush_pc", pc, 32'h0040_0010);
    tick(0, 0, 0, 1, 32'h1234_5678);
    chk("t6_rst_pc", pc, RESET_PC);
    chk("t6_rst_err", {31'd0, misalign_err}, 32'd0);
    chk("t6_rst_cnt", fetch_count, 32'd0);

    // address wrap at the top of the address space
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 32'hFFFF_FFF8);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_pc4", ifid_pc4, 32'h0000_0000);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        r, st, fl, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      rv = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       rp = $urandom;
        1:       rp = 32'hFFFF_FFF0 | {28'd0, 4'($urandom)};
        default: rp = RESET_PC + {22'd0, 10'($urandom)};
      endcase
      tick(r, st, fl, rv, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
